// File: rtl/imem_pkg.sv
// Shared constants and FSM encoding for the dual-bank instruction-pair responder.
package imem_pkg;

    localparam int unsigned IMEM_ADDR_W = 10;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } imem_state_e;

endpackage

// File: rtl/imem_pair_responder_bank.sv
// Single write port, synchronous-read 32-bit RAM; one instance per address parity.
module imem_bank #(
    parameter int unsigned IDX_W = 9
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/imem_pair_responder.sv
// Serves {mem[a+1], mem[a]} with one-cycle latency from even/odd banks, and
// fills memory through a streaming load port that stalls fetch while active.
module imem_pair_responder #(
    parameter int unsigned ADDR_W   = imem_pkg::IMEM_ADDR_W,
    parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [63:0]       data_o,
    output logic              stall_o,
    input  logic              load_start_i,
    input  logic [ADDR_W-1:0] load_base_i,
    input  logic              load_valid_i,
    input  logic [31:0]       load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic [ADDR_W:0]   load_count_o
);

    import imem_pkg::*;

    localparam int unsigned IDX_W = ADDR_W - 1;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_c;
    logic              nop_q;
    logic              a0_q;

    logic [IDX_W-1:0]  rd_idx_c;
    logic [IDX_W-1:0]  even_idx_c;
    logic [31:0]       even_rdata, odd_rdata;
    logic              even_we_c, odd_we_c;

    // An odd address needs the next even word, which lives one row further down.
    assign rd_idx_c   = addr_i[ADDR_W-1:1];
    assign even_idx_c = addr_i[0] ? rd_idx_c + IDX_W'(1) : rd_idx_c;

    // Writes are suppressed on a reset edge so an abandoned session leaves no trace.
    assign even_we_c = we_c & reset_n_i & ~wptr_q[0];
    assign odd_we_c  = we_c & reset_n_i &  wptr_q[0];

    imem_bank #(.IDX_W(IDX_W)) u_even (
        .clk   (clock_i),
        .we    (even_we_c),
        .waddr (wptr_q[ADDR_W-1:1]),
        .wdata (load_data_i),
        .raddr (even_idx_c),
        .rdata (even_rdata)
    );

    imem_bank #(.IDX_W(IDX_W)) u_odd (
        .clk   (clock_i),
        .we    (odd_we_c),
        .waddr (wptr_q[ADDR_W-1:1]),
        .wdata (load_data_i),
        .raddr (rd_idx_c),
        .rdata (odd_rdata)
    );

    // Load session control: pointer/count updates and bank write strobe.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        we_c    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load_start_i) begin
                    wptr_d  = load_base_i;
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_valid_i) begin
                    we_c   = 1'b1;
                    wptr_d = wptr_q + ADDR_W'(1);
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (load_last_i) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            cnt_q        <= '0;
            stall_o      <= 1'b0;
            load_ready_o <= 1'b0;
            nop_q        <= 1'b1;
            a0_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            stall_o      <= (state_d != ST_IDLE);
            load_ready_o <= (state_d == ST_LOAD);
            nop_q        <= (state_d != ST_IDLE);
            a0_q         <= addr_i[0];
        end
    end

    assign load_count_o = cnt_q;

    always_comb begin
        if (nop_q) begin
            data_o = {NOP_WORD, NOP_WORD};
        end else if (a0_q) begin
            data_o = {even_rdata, odd_rdata};
        end else begin
            data_o = {odd_rdata, even_rdata};
        end
    end

endmodule
